// File: rtl/input_vc_buffer.sv
// Per-input-port virtual-channel buffer: one FIFO per lane, packet-granular round-robin lane select.
// Latency: a flit written at edge N is presentable on dout after edge N; credits lag their pop by one cycle.
// Backpressure: dout held while dout_ready is low; writes to a full lane are dropped (sticky overflow) unless that lane pops the same cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   din / din_valid / din_lane         : incoming flit and its target lane
//   dout / dout_valid / dout_lane      : selected lane head towards vc_allocator, consumed by dout_ready
//   credit_valid / credit_lane         : registered one-credit-per-pop return to upstream
//   overflow                           : sticky flag for dropped writes (full lane or bad lane index)
module input_vc_buffer #(
   parameter int LANES_PER_CHANNEL = 2,
   parameter int VC_DEPTH          = 5,
   parameter int FLIT_SIZE         = 32,
   localparam int LW = (LANES_PER_CHANNEL > 1) ? $clog2(LANES_PER_CHANNEL) : 1,
   localparam int CW = $clog2(VC_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [FLIT_SIZE-1:0] din,
   input  logic                 din_valid,
   input  logic [LW-1:0]        din_lane,
   output logic [FLIT_SIZE-1:0] dout,
   output logic                 dout_valid,
   output logic [LW-1:0]        dout_lane,
   input  logic                 dout_ready,
   output logic                 credit_valid,
   output logic [LW-1:0]        credit_lane,
   output logic                 overflow
);

   localparam int PW = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;

   localparam logic [1:0] TYPE_HEAD = 2'b10;
   localparam logic [1:0] TYPE_TAIL = 2'b01;

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

   logic [FLIT_SIZE-1:0] mem_q [LANES_PER_CHANNEL][VC_DEPTH];
   logic [PW-1:0]        wr_ptr_q [LANES_PER_CHANNEL];
   logic [PW-1:0]        wr_ptr_d [LANES_PER_CHANNEL];
   logic [PW-1:0]        rd_ptr_q [LANES_PER_CHANNEL];
   logic [PW-1:0]        rd_ptr_d [LANES_PER_CHANNEL];
   logic [CW-1:0]        cnt_q    [LANES_PER_CHANNEL];
   logic [CW-1:0]        cnt_d    [LANES_PER_CHANNEL];

   state_t               state_q;
   logic [LW-1:0]        rr_ptr_q;
   logic [LW-1:0]        lock_lane_q;
   logic                 credit_valid_q;
   logic [LW-1:0]        credit_lane_q;
   logic                 overflow_q;

   logic                 sel_vld;
   logic [LW-1:0]        sel_lane;
   logic                 pop;
   logic [1:0]           pop_type;
   logic                 lane_ok;
   logic                 lane_full;
   logic                 wr_en;
   logic [LANES_PER_CHANNEL-1:0] push_v;
   logic [LANES_PER_CHANNEL-1:0] pop_v;

   function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] l);
      return (int'(l) == LANES_PER_CHANNEL - 1) ? '0 : l + LW'(1);
   endfunction

   // Lane select. While locked only the owning lane may be shown, so another
   // packet can never slip between a head and its tail.
   always_comb begin
      int idx;
      idx      = 0;
      sel_vld  = 1'b0;
      sel_lane = '0;
      if (state_q == LOCKED) begin
         sel_vld  = (cnt_q[lock_lane_q] != '0);
         sel_lane = lock_lane_q;
      end else begin
         // Walk from the farthest offset down so the lane nearest rr_ptr wins.
         for (int i = LANES_PER_CHANNEL - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= LANES_PER_CHANNEL) idx = idx - LANES_PER_CHANNEL;
            if (cnt_q[idx] != '0) begin
               sel_vld  = 1'b1;
               sel_lane = LW'(idx);
            end
         end
      end
   end

   assign dout_valid = sel_vld;
   assign dout_lane  = sel_vld ? sel_lane : '0;
   assign dout       = sel_vld ? mem_q[sel_lane][rd_ptr_q[sel_lane]] : '0;
   assign pop        = sel_vld && dout_ready;
   assign pop_type   = dout[FLIT_SIZE-1 -: 2];

   // A full lane still accepts a write when it is being drained in the same cycle.
   assign lane_ok   = int'(din_lane) < LANES_PER_CHANNEL;
   assign lane_full = lane_ok && (cnt_q[din_lane] == CW'(VC_DEPTH));
   assign wr_en     = din_valid && lane_ok && (!lane_full || (pop && (sel_lane == din_lane)));

   always_comb begin
      for (int l = 0; l < LANES_PER_CHANNEL; l++) begin
         push_v[l]   = wr_en && (int'(din_lane) == l);
         pop_v[l]    = pop && (int'(sel_lane) == l);
         wr_ptr_d[l] = wr_ptr_q[l];
         rd_ptr_d[l] = rd_ptr_q[l];
         cnt_d[l]    = cnt_q[l];
         // Depth need not be a power of two, so wrap by compare.
         if (push_v[l])
            wr_ptr_d[l] = (wr_ptr_q[l] == PW'(VC_DEPTH - 1)) ? '0 : wr_ptr_q[l] + PW'(1);
         if (pop_v[l])
            rd_ptr_d[l] = (rd_ptr_q[l] == PW'(VC_DEPTH - 1)) ? '0 : rd_ptr_q[l] + PW'(1);
         if (push_v[l] && !pop_v[l])
            cnt_d[l] = cnt_q[l] + CW'(1);
         else if (!push_v[l] && pop_v[l])
            cnt_d[l] = cnt_q[l] - CW'(1);
      end
   end

   // Flit storage carries no reset; empty lanes are never presented.
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES_PER_CHANNEL; l++) begin
         if (push_v[l]) mem_q[l][wr_ptr_q[l]] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int l = 0; l < LANES_PER_CHANNEL; l++) begin
            wr_ptr_q[l] <= '0;
            rd_ptr_q[l] <= '0;
            cnt_q[l]    <= '0;
         end
         credit_valid_q <= 1'b0;
         credit_lane_q  <= '0;
         overflow_q     <= 1'b0;
      end else begin
         for (int l = 0; l < LANES_PER_CHANNEL; l++) begin
            wr_ptr_q[l] <= wr_ptr_d[l];
            rd_ptr_q[l] <= rd_ptr_d[l];
            cnt_q[l]    <= cnt_d[l];
         end
         credit_valid_q <= pop;
         if (pop) credit_lane_q <= sel_lane;
         if (din_valid && !wr_en) overflow_q <= 1'b1;
      end
   end

   // Packet-lock state machine. Body/tail popped while unlocked is a protocol
   // violation; it is delivered and treated like a single-flit packet.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= UNLOCKED;
         rr_ptr_q    <= '0;
         lock_lane_q <= '0;
      end else if (pop) begin
         case (state_q)
            UNLOCKED: begin
               if (pop_type == TYPE_HEAD) begin
                  state_q     <= LOCKED;
                  lock_lane_q <= sel_lane;
               end else begin
                  rr_ptr_q <= next_lane(sel_lane);
               end
            end
            LOCKED: begin
               if (pop_type == TYPE_TAIL) begin
                  state_q  <= UNLOCKED;
                  rr_ptr_q <= next_lane(lock_lane_q);
               end
            end
            default: state_q <= UNLOCKED;
         endcase
      end
   end

   assign credit_valid = credit_valid_q;
   assign credit_lane  = credit_lane_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer with hand-computed expectations.
module tb_input_vc_buffer;

   localparam logic [1:0] HD = 2'b10;
   localparam logic [1:0] BD = 2'b00;
   localparam logic [1:0] TL = 2'b01;
   localparam logic [1:0] HT = 2'b11;

   logic        clk;
   logic        reset;
   logic [31:0] din;
   logic        din_valid;
   logic [0:0]  din_lane;
   logic [31:0] dout;
   logic        dout_valid;
   logic [0:0]  dout_lane;
   logic        dout_ready;
   logic        credit_valid;
   logic [0:0]  credit_lane;
   logic        overflow;

   int n_checks;
   int n_fail;

   input_vc_buffer #(.LANES_PER_CHANNEL(2), .VC_DEPTH(5), .FLIT_SIZE(32)) dut (
      .clk(clk), .reset(reset),
      .din(din), .din_valid(din_valid), .din_lane(din_lane),
      .dout(dout), .dout_valid(dout_valid), .dout_lane(dout_lane), .dout_ready(dout_ready),
      .credit_valid(credit_valid), .credit_lane(credit_lane), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] fl(input logic [1:0] t, input int p);
      return {t, 30'(p)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic lane, input logic [31:0] f);
      din_valid = 1'b1;
      din_lane  = lane;
      din       = f;
      tick();
      din_valid = 1'b0;
   endtask

   logic [31:0] exp_f [12];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b0; din = '0; din_valid = 1'b0; din_lane = '0; dout_ready = 1'b0;
      tick(); tick();
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_dout_lane", dout_lane, 0);
      chk("rst_credit_valid", credit_valid, 0);
      chk("rst_overflow", overflow, 0);
      reset = 1'b1;
      tick();

      // Single lane fill/drain on lane 1
      exp_f[0] = fl(HD, 100); exp_f[1] = fl(BD, 101); exp_f[2] = fl(BD, 102);
      exp_f[3] = fl(BD, 103); exp_f[4] = fl(TL, 104);
      for (int i = 0; i < 5; i++) wr(1'b1, exp_f[i]);
      chk("fill_count", dut.cnt_q[1], 5);
      chk("fill_overflow_clear", overflow, 0);
      chk("fill_head_shown", dout, exp_f[0]);
      wr(1'b1, fl(HT, 999));
      chk("sixth_write_overflow", overflow, 1);
      chk("sixth_write_count", dut.cnt_q[1], 5);
      dout_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("drain_valid", dout_valid, 1);
         chk("drain_data", dout, exp_f[i]);
         chk("drain_lane", dout_lane, 1);
         tick();
         chk("drain_credit_valid", credit_valid, 1);
         chk("drain_credit_lane", credit_lane, 1);
      end
      chk("drain_empty", dout_valid, 0);
      tick();
      chk("drain_no_credit", credit_valid, 0);
      chk("overflow_sticky", overflow, 1);
      reset = 1'b0; #1;
      chk("overflow_cleared", overflow, 0);
      reset = 1'b1;
      dout_ready = 1'b0;
      tick();

      // No interleaving, lane-0 tail arriving late
      wr(1'b0, fl(HD, 200));
      wr(1'b0, fl(BD, 201));
      wr(1'b1, fl(HT, 300));
      dout_ready = 1'b1;
      chk("ni_l0_head", dout, fl(HD, 200));
      chk("ni_l0_head_lane", dout_lane, 0);
      tick();
      chk("ni_l0_body", dout, fl(BD, 201));
      tick();
      chk("ni_locked_stall", dout_valid, 0);
      tick();
      chk("ni_locked_stall2", dout_valid, 0);
      wr(1'b0, fl(TL, 202));
      chk("ni_l0_tail", dout, fl(TL, 202));
      chk("ni_l0_tail_lane", dout_lane, 0);
      tick();
      chk("ni_l1_ht", dout, fl(HT, 300));
      chk("ni_l1_ht_lane", dout_lane, 1);
      tick();
      chk("ni_empty", dout_valid, 0);
      dout_ready = 1'b0;

      // Round-robin fairness over single-flit packets
      for (int i = 0; i < 3; i++) begin
         wr(1'b0, fl(HT, 400 + i));
         wr(1'b1, fl(HT, 500 + i));
      end
      dout_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("rr_lane", dout_lane, 64'(i % 2));
         chk("rr_data", dout, fl(HT, ((i % 2) == 0) ? 400 + i / 2 : 500 + i / 2));
         tick();
      end
      chk("rr_empty", dout_valid, 0);
      dout_ready = 1'b0;

      // Full lane with simultaneous pop and write
      for (int i = 0; i < 5; i++) wr(1'b0, fl(HT, 600 + i));
      chk("full_count", dut.cnt_q[0], 5);
      dout_ready = 1'b1;
      chk("full_rw_pop_data", dout, fl(HT, 600));
      wr(1'b0, fl(HT, 605));
      dout_ready = 1'b0;
      chk("full_rw_count", dut.cnt_q[0], 5);
      chk("full_rw_overflow", overflow, 0);
      dout_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         chk("full_rw_order", dout, fl(HT, 600 + i));
         tick();
      end
      chk("full_rw_empty", dout_valid, 0);

      // Wrap-around streaming through lane 0
      for (int i = 0; i < 12; i++) exp_f[i] = fl(HT, 700 + i * 3);
      for (int i = 0; i <= 12; i++) begin
         if (i < 12) begin
            din_valid = 1'b1; din_lane = 1'b0; din = exp_f[i];
         end else begin
            din_valid = 1'b0;
         end
         if (i > 0) chk("wrap_data", dout, exp_f[i - 1]);
         tick();
      end
      chk("wrap_empty", dout_valid, 0);
      chk("wrap_overflow", overflow, 0);
      dout_ready = 1'b0;

      // Async reset while locked on lane 1
      wr(1'b1, fl(HD, 800));
      for (int i = 1; i <= 3; i++) wr(1'b1, fl(BD, 800 + i));
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("ar_locked_valid", dout_valid, 1);
      chk("ar_locked_data", dout, fl(BD, 801));
      chk("ar_credit_before", credit_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_dout_valid_now", dout_valid, 0);
      chk("ar_credit_now", credit_valid, 0);
      #2;
      reset = 1'b1;
      wr(1'b1, fl(HT, 900));
      chk("ar_no_stale_credit", credit_valid, 0);
      chk("ar_unlocked_l1_shown", dout_lane, 1);
      wr(1'b0, fl(HD, 901));
      dout_ready = 1'b1;
      chk("ar_first_lane0", dout_lane, 0);
      chk("ar_first_data", dout, fl(HD, 901));
      tick();
      dout_ready = 1'b0;
      chk("ar_credit_lane0", credit_lane, 0);
      chk("ar_locked_l0_stall", dout_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
